// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - initiator side of the FP adder start/done strobe protocol
// Takes one operand pair, strobes the adder, waits for done (with watchdog), holds the result.
module fp_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              start_out,
  output logic [DATA_W-1:0] opa_out,
  output logic [DATA_W-1:0] opb_out,
  input  logic              done_in,
  input  logic [DATA_W-1:0] sum_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             got_done;
  logic             timed_out;
  logic             handshake;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // done_in only matters in WAIT; done beats the watchdog on the same cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    got_done  = 1'b0;
    timed_out = 1'b0;
    handshake = 1'b0;
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        accept = req_valid;
        if (req_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        got_done  = done_in;
        timed_out = !done_in && (count == LAST);
        if (got_done || timed_out) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        handshake = res_ready;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      start_out <= 1'b0;
      opa_out   <= '0;
      opb_out   <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      start_out <= accept;
      if (accept) begin
        opa_out <= req_a;
        opb_out <= req_b;
      end
      // saturating watchdog; leaves WAIT at LAST so it never wraps
      if (state == S_ISSUE)
        count <= '0;
      else if (state == S_WAIT && count != LAST)
        count <= count + 1'b1;
      if (got_done) begin
        res_data  <= sum_in;
        res_err   <= 1'b0;
        res_valid <= 1'b1;
      end else if (timed_out) begin
        res_data  <= '0;
        res_err   <= 1'b1;
        res_valid <= 1'b1;
      end else if (handshake) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb/tb_fp_op_sequencer.sv - bench for fp_op_sequencer
// Table of full transactions plus hand sequences for stray done, back-to-back and reset.
module tb_fp_op_sequencer;

  localparam int TO = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        start_out;
  logic [31:0] opa_out;
  logic [31:0] opb_out;
  logic        done_in;
  logic [31:0] sum_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  fp_op_sequencer #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(7)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .start_out (start_out),
    .opa_out   (opa_out),
    .opb_out   (opb_out),
    .done_in   (done_in),
    .sum_in    (sum_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    int          done_at;
    int          exp_at;
    logic [31:0] exp_data;
    logic        exp_err;
    int          hold;
    logic        stray;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    req_a     = v.a;
    req_b     = v.b;
    req_valid = 1'b1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("start_issue", {31'd0, start_out}, 32'd1);
    check("busy_issue", {31'd0, busy}, 32'd1);
    check("req_ready_issue", {31'd0, req_ready}, 32'd0);
    check("opa", opa_out, v.a);
    check("opb", opb_out, v.b);
    if (v.stray) begin
      done_in = 1'b1;
      sum_in  = 32'hDEADBEEF;
    end
    tick();
    done_in = 1'b0;
    check("start_wait", {31'd0, start_out}, 32'd0);
    check("res_valid_wait0", {31'd0, res_valid}, 32'd0);
    for (int c = 0; c <= v.exp_at; c++) begin
      if (c == v.done_at) begin
        done_in = 1'b1;
        sum_in  = v.sum;
      end else begin
        done_in = 1'b0;
        sum_in  = 32'h0BAD0BAD;
      end
      tick();
      if (c < v.exp_at) begin
        check("res_valid_early", {31'd0, res_valid}, 32'd0);
      end else begin
        check("res_valid_on_time", {31'd0, res_valid}, 32'd1);
        check("res_data", res_data, v.exp_data);
        check("res_err", {31'd0, res_err}, {31'd0, v.exp_err});
      end
    end
    done_in = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_data", res_data, v.exp_data);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs_valid_low", {31'd0, res_valid}, 32'd0);
    check("hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("hs_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 33, 33, 32'h40400000, 1'b0, 10, 1'b0};
    vecs[1] = '{32'h00000001, 32'h00000002, 32'h12345678, 0, 0, 32'h12345678, 1'b0, 0, 1'b1};
    vecs[2] = '{32'hAAAAAAAA, 32'h55555555, 32'h77777777, TO, TO - 1, 32'h00000000, 1'b1, 2, 1'b0};
    vecs[3] = '{32'h11111111, 32'h22222222, 32'hCAFEF00D, TO - 1, TO - 1, 32'hCAFEF00D, 1'b0, 1, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 5, 5, 32'hFFFFFFFF, 1'b0, 3, 1'b0};

    rst_in    = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    done_in   = 1'b0;
    sum_in    = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_start", {31'd0, start_out}, 32'd0);
    rst_in = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // stray done while idle
    done_in = 1'b1;
    sum_in  = 32'h99999999;
    tick();
    tick();
    done_in = 1'b0;
    check("idle_stray_valid", {31'd0, res_valid}, 32'd0);
    check("idle_stray_busy", {31'd0, busy}, 32'd0);
    check("idle_stray_start", {31'd0, start_out}, 32'd0);

    // request held through the result handshake is taken only the cycle after
    req_a     = 32'h00000001;
    req_b     = 32'h00000002;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("b2b_start1", {31'd0, start_out}, 32'd1);
    tick();
    done_in = 1'b1;
    sum_in  = 32'h00000003;
    tick();
    done_in = 1'b0;
    check("b2b_valid1", {31'd0, res_valid}, 32'd1);
    check("b2b_data1", res_data, 32'h00000003);
    res_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'h00000005;
    req_b     = 32'h00000006;
    tick();
    res_ready = 1'b0;
    check("b2b_no_start_hs", {31'd0, start_out}, 32'd0);
    check("b2b_ready_after_hs", {31'd0, req_ready}, 32'd1);
    check("b2b_opa_held", opa_out, 32'h00000001);
    tick();
    req_valid = 1'b0;
    check("b2b_start2", {31'd0, start_out}, 32'd1);
    check("b2b_opa2", opa_out, 32'h00000005);
    tick();
    check("b2b_start2_once", {31'd0, start_out}, 32'd0);
    tick();
    tick();

    // asynchronous reset in the middle of WAIT
    #2 rst_in = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_opa", opa_out, 32'd0);
    check("arst_opb", opb_out, 32'd0);
    check("arst_valid", {31'd0, res_valid}, 32'd0);
    check("arst_err", {31'd0, res_err}, 32'd0);
    tick();
    rst_in  = 1'b0;
    done_in = 1'b1;
    sum_in  = 32'h44444444;
    tick();
    done_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_start", {31'd0, start_out}, 32'd0);
      check("post_rst_valid", {31'd0, res_valid}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
